// File: rtl/conflict_batch.sv
// Collects transactions into conflict-free batches and streams each closed batch out with TLAST.
// Optional per-reason close counters are compiled in with `define BATCH_STATS_EN.
module conflict_batch #(
    parameter int ID_W           = 64,
    parameter int DEP_W          = 1024,
    parameter int MAX_BATCH_SIZE = 8,
    parameter int TIMEOUT_W      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [TIMEOUT_W-1:0]                 cfg_timeout,
    input  logic                                 flush,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic [ID_W-1:0]                      s_axis_tdata_owner_programID,
    input  logic [DEP_W-1:0]                     s_axis_tdata_read_dependencies,
    input  logic [DEP_W-1:0]                     s_axis_tdata_write_dependencies,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic [ID_W-1:0]                      m_axis_tdata_owner_programID,
    output logic [DEP_W-1:0]                     m_axis_tdata_read_dependencies,
    output logic [DEP_W-1:0]                     m_axis_tdata_write_dependencies,
    output logic                                 batch_completed,
    output logic [$clog2(MAX_BATCH_SIZE+1)-1:0]  batch_size,
    output logic [1:0]                           close_reason,
`ifdef BATCH_STATS_EN
    output logic [31:0]                          stat_full_closes,
    output logic [31:0]                          stat_timeout_closes,
    output logic [31:0]                          stat_conflict_closes,
    output logic [31:0]                          stat_flush_closes,
`endif
    output logic [31:0]                          transactions_processed
);

    localparam int CNT_W = $clog2(MAX_BATCH_SIZE + 1);
    localparam int IDX_W = $clog2(MAX_BATCH_SIZE);

    localparam logic [1:0] R_FULL     = 2'b00;
    localparam logic [1:0] R_TIMEOUT  = 2'b01;
    localparam logic [1:0] R_CONFLICT = 2'b10;
    localparam logic [1:0] R_FLUSH    = 2'b11;

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t                state;
    logic [ID_W-1:0]       mem_id [MAX_BATCH_SIZE];
    logic [DEP_W-1:0]      mem_rd [MAX_BATCH_SIZE];
    logic [DEP_W-1:0]      mem_wr [MAX_BATCH_SIZE];
    logic [CNT_W-1:0]      count;
    logic [DEP_W-1:0]      acc_rd;
    logic [DEP_W-1:0]      acc_wr;
    logic [TIMEOUT_W-1:0]  idle_cnt;
    logic [IDX_W-1:0]      rd_idx;

    logic                  conflict;
    logic                  hs;
    logic                  do_close;
    logic [1:0]            reason;
    logic [CNT_W-1:0]      count_inc;
    logic [CNT_W-1:0]      close_size;
    logic [TIMEOUT_W:0]    idle_inc;
    logic [IDX_W-1:0]      nxt_idx;

    // The accumulators are all-zero on an empty batch, so the first transaction can never conflict.
    always_comb begin
        conflict      = (count != '0) &&
                        (|((s_axis_tdata_write_dependencies & (acc_rd | acc_wr)) |
                           (s_axis_tdata_read_dependencies & acc_wr)));
        s_axis_tready = (state == COLLECT) && (count < CNT_W'(MAX_BATCH_SIZE)) && !conflict;
        hs            = s_axis_tvalid && s_axis_tready;
        count_inc     = count + CNT_W'(1);
        close_size    = hs ? count_inc : count;
        idle_inc      = {1'b0, idle_cnt} + (TIMEOUT_W+1)'(1);
        nxt_idx       = rd_idx + IDX_W'(1);
        do_close      = 1'b0;
        reason        = R_FULL;
        if (state == COLLECT) begin
            if (hs && (count_inc == CNT_W'(MAX_BATCH_SIZE))) begin
                do_close = 1'b1;
                reason   = R_FULL;
            end else if (s_axis_tvalid && conflict) begin
                do_close = 1'b1;
                reason   = R_CONFLICT;
            end else if (flush && (count != '0) && !hs) begin
                do_close = 1'b1;
                reason   = R_FLUSH;
            end else if ((cfg_timeout != '0) && (idle_inc >= {1'b0, cfg_timeout}) &&
                         (count != '0) && !hs) begin
                do_close = 1'b1;
                reason   = R_TIMEOUT;
            end
        end
    end

    // Entry storage carries no reset; count and the drain index decide what is meaningful.
    always_ff @(posedge clk) begin
        if (hs) begin
            mem_id[count[IDX_W-1:0]] <= s_axis_tdata_owner_programID;
            mem_rd[count[IDX_W-1:0]] <= s_axis_tdata_read_dependencies;
            mem_wr[count[IDX_W-1:0]] <= s_axis_tdata_write_dependencies;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                           <= COLLECT;
            count                           <= '0;
            acc_rd                          <= '0;
            acc_wr                          <= '0;
            idle_cnt                        <= '0;
            rd_idx                          <= '0;
            m_axis_tvalid                   <= 1'b0;
            m_axis_tlast                    <= 1'b0;
            m_axis_tdata_owner_programID    <= '0;
            m_axis_tdata_read_dependencies  <= '0;
            m_axis_tdata_write_dependencies <= '0;
            batch_completed                 <= 1'b0;
            batch_size                      <= '0;
            close_reason                    <= '0;
            transactions_processed          <= '0;
`ifdef BATCH_STATS_EN
            stat_full_closes                <= '0;
            stat_timeout_closes             <= '0;
            stat_conflict_closes            <= '0;
            stat_flush_closes               <= '0;
`endif
        end else begin
            batch_completed <= 1'b0;
            case (state)
                COLLECT: begin
                    if (hs) begin
                        count    <= count_inc;
                        acc_rd   <= acc_rd | s_axis_tdata_read_dependencies;
                        acc_wr   <= acc_wr | s_axis_tdata_write_dependencies;
                        idle_cnt <= '0;
                    end else if ((count != '0) && (idle_cnt != '1)) begin
                        idle_cnt <= idle_cnt + TIMEOUT_W'(1);
                    end
                    // Entry 0 is always stored before any close, so it can be presented right away.
                    if (do_close) begin
                        state                           <= DRAIN;
                        batch_size                      <= close_size;
                        close_reason                    <= reason;
                        rd_idx                          <= '0;
                        m_axis_tvalid                   <= 1'b1;
                        m_axis_tlast                    <= (close_size == CNT_W'(1));
                        m_axis_tdata_owner_programID    <= mem_id[0];
                        m_axis_tdata_read_dependencies  <= mem_rd[0];
                        m_axis_tdata_write_dependencies <= mem_wr[0];
`ifdef BATCH_STATS_EN
                        case (reason)
                            R_FULL:     stat_full_closes     <= stat_full_closes + 32'd1;
                            R_TIMEOUT:  stat_timeout_closes  <= stat_timeout_closes + 32'd1;
                            R_CONFLICT: stat_conflict_closes <= stat_conflict_closes + 32'd1;
                            default:    stat_flush_closes    <= stat_flush_closes + 32'd1;
                        endcase
`endif
                    end
                end
                DRAIN: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        transactions_processed <= transactions_processed + 32'd1;
                        if (m_axis_tlast) begin
                            state           <= COLLECT;
                            m_axis_tvalid   <= 1'b0;
                            m_axis_tlast    <= 1'b0;
                            batch_completed <= 1'b1;
                            count           <= '0;
                            acc_rd          <= '0;
                            acc_wr          <= '0;
                            idle_cnt        <= '0;
                        end else begin
                            rd_idx                          <= nxt_idx;
                            m_axis_tlast                    <= ((CNT_W'(nxt_idx) + CNT_W'(1)) == batch_size);
                            m_axis_tdata_owner_programID    <= mem_id[nxt_idx];
                            m_axis_tdata_read_dependencies  <= mem_rd[nxt_idx];
                            m_axis_tdata_write_dependencies <= mem_wr[nxt_idx];
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_conflict_batch.sv
// Self-checking bench for conflict_batch: a cycle table for the conflict case plus directed sequences.
// Build with +define+BATCH_STATS_EN to also check the per-reason close counters.
module tb_conflict_batch;

    localparam int ID_W  = 16;
    localparam int DEP_W = 32;
    localparam int MAXB  = 8;
    localparam int TW    = 16;
    localparam int CW    = $clog2(MAXB + 1);

    logic              clk;
    logic              rst_n;
    logic [TW-1:0]     cfg_timeout;
    logic              flush;
    logic              s_valid;
    logic              s_ready;
    logic [ID_W-1:0]   s_id;
    logic [DEP_W-1:0]  s_rd;
    logic [DEP_W-1:0]  s_wr;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [ID_W-1:0]   m_id;
    logic [DEP_W-1:0]  m_rd;
    logic [DEP_W-1:0]  m_wr;
    logic              done;
    logic [CW-1:0]     bsize;
    logic [1:0]        reason;
    logic [31:0]       tp;
`ifdef BATCH_STATS_EN
    logic [31:0]       st_full, st_tmo, st_conf, st_flush;
`endif

    int total = 0;
    int bad   = 0;

    conflict_batch #(.ID_W(ID_W), .DEP_W(DEP_W), .MAX_BATCH_SIZE(MAXB), .TIMEOUT_W(TW)) dut (
        .clk                             (clk),
        .rst_n                           (rst_n),
        .cfg_timeout                     (cfg_timeout),
        .flush                           (flush),
        .s_axis_tvalid                   (s_valid),
        .s_axis_tready                   (s_ready),
        .s_axis_tdata_owner_programID    (s_id),
        .s_axis_tdata_read_dependencies  (s_rd),
        .s_axis_tdata_write_dependencies (s_wr),
        .m_axis_tvalid                   (m_valid),
        .m_axis_tready                   (m_ready),
        .m_axis_tlast                    (m_last),
        .m_axis_tdata_owner_programID    (m_id),
        .m_axis_tdata_read_dependencies  (m_rd),
        .m_axis_tdata_write_dependencies (m_wr),
        .batch_completed                 (done),
        .batch_size                      (bsize),
        .close_reason                    (reason),
`ifdef BATCH_STATS_EN
        .stat_full_closes                (st_full),
        .stat_timeout_closes             (st_tmo),
        .stat_conflict_closes            (st_conf),
        .stat_flush_closes               (st_flush),
`endif
        .transactions_processed          (tp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [ID_W-1:0]  id;
        logic [DEP_W-1:0] rd;
        logic [DEP_W-1:0] wr;
        logic             fl;
        logic             exp_sready;
        logic             exp_mvalid;
        logic             exp_mlast;
        logic [ID_W-1:0]  exp_mid;
        logic             exp_done;
        logic [1:0]       exp_reason;
        logic [CW-1:0]    exp_size;
    } vec_t;

    vec_t vecs[7];

    // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
    task automatic applyStimulus(input logic v, input logic [ID_W-1:0] id, input logic [DEP_W-1:0] rd,
                                 input logic [DEP_W-1:0] wr, input logic fl, input logic mr);
        @(negedge clk);
        s_valid = v;
        s_id    = id;
        s_rd    = rd;
        s_wr    = wr;
        flush   = fl;
        m_ready = mr;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drainBatch(output int got, output int pulses);
        got    = 0;
        pulses = 0;
        for (int c = 0; c < MAXB + 4; c++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
            if (m_valid) got++;
            if (done) pulses++;
        end
    endtask

    initial begin
        automatic int idx    = 0;
        automatic int pulses = 0;
        automatic int got    = 0;
        automatic int n      = 0;
        automatic logic seen = 1'b0;

        // Conflict scenario: A writes bit 5, B reads bit 5, then B is flushed out as its own batch.
        vecs[0] = '{1'b1, 16'h00A0, 32'h0, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0,    1'b0, 2'd0, 4'd0};
        vecs[1] = '{1'b1, 16'h00B0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 2'd0, 4'd0};
        vecs[2] = '{1'b1, 16'h00B0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00A0, 1'b0, 2'd2, 4'd1};
        vecs[3] = '{1'b1, 16'h00B0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0,    1'b1, 2'd0, 4'd0};
        vecs[4] = '{1'b0, 16'h0,    32'h0,  32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0,    1'b0, 2'd0, 4'd0};
        vecs[5] = '{1'b0, 16'h0,    32'h0,  32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00B0, 1'b0, 2'd3, 4'd1};
        vecs[6] = '{1'b0, 16'h0,    32'h0,  32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0,    1'b1, 2'd0, 4'd0};

        rst_n = 1'b0; cfg_timeout = '0; flush = 1'b0; s_valid = 1'b0;
        s_id = '0; s_rd = '0; s_wr = '0; m_ready = 1'b0;
        @(negedge clk); #1;
        checkOutput("rst_mvalid", 64'(m_valid), 64'd0);
        checkOutput("rst_mlast",  64'(m_last),  64'd0);
        checkOutput("rst_mid",    64'(m_id),    64'd0);
        checkOutput("rst_done",   64'(done),    64'd0);
        checkOutput("rst_size",   64'(bsize),   64'd0);
        checkOutput("rst_reason", 64'(reason),  64'd0);
        checkOutput("rst_tp",     64'(tp),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] full batch of 8");
        for (int i = 0; i < MAXB; i++) begin
            applyStimulus(1'b1, ID_W'(16'h10 + i), '0, DEP_W'(1) << i, 1'b0, 1'b1);
            checkOutput("t1_sready", 64'(s_ready), 64'd1);
        end
        idx = 0; pulses = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
            if (done) pulses++;
            if (m_valid) begin
                checkOutput("t1_id",     64'(m_id),   64'(16'h10 + idx));
                checkOutput("t1_wr",     64'(m_wr),   64'(DEP_W'(1) << idx));
                checkOutput("t1_last",   64'(m_last), 64'(idx == MAXB - 1));
                checkOutput("t1_reason", 64'(reason), 64'd0);
                checkOutput("t1_size",   64'(bsize),  64'd8);
                idx++;
            end
        end
        checkOutput("t1_count",  64'(idx),    64'd8);
        checkOutput("t1_pulses", 64'(pulses), 64'd1);
        checkOutput("t1_tp",     64'(tp),     64'd8);

        $display("[TB] conflict table");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].v, vecs[i].id, vecs[i].rd, vecs[i].wr, vecs[i].fl, 1'b1);
            checkOutput($sformatf("t2_sready[%0d]", i), 64'(s_ready), 64'(vecs[i].exp_sready));
            checkOutput($sformatf("t2_mvalid[%0d]", i), 64'(m_valid), 64'(vecs[i].exp_mvalid));
            checkOutput($sformatf("t2_done[%0d]", i),   64'(done),    64'(vecs[i].exp_done));
            if (vecs[i].exp_mvalid) begin
                checkOutput($sformatf("t2_mlast[%0d]", i),  64'(m_last), 64'(vecs[i].exp_mlast));
                checkOutput($sformatf("t2_mid[%0d]", i),    64'(m_id),   64'(vecs[i].exp_mid));
                checkOutput($sformatf("t2_reason[%0d]", i), 64'(reason), 64'(vecs[i].exp_reason));
                checkOutput($sformatf("t2_size[%0d]", i),   64'(bsize),  64'(vecs[i].exp_size));
            end
        end
        checkOutput("t2_tp", 64'(tp), 64'd10);

        $display("[TB] timeout of 10 idle cycles");
        cfg_timeout = TW'(10);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, ID_W'(16'h30 + i), '0, DEP_W'(1) << (8 + i), 1'b0, 1'b0);
            checkOutput("t3_sready", 64'(s_ready), 64'd1);
        end
        n = 0; seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
            if (m_valid) seen = 1'b1;
            else n++;
        end
        checkOutput("t3_seen",   64'(seen),   64'd1);
        checkOutput("t3_idle",   64'(n),      64'd10);
        checkOutput("t3_reason", 64'(reason), 64'd1);
        checkOutput("t3_size",   64'(bsize),  64'd3);
        drainBatch(got, pulses);
        checkOutput("t3_got",    64'(got),    64'd3);
        checkOutput("t3_pulses", 64'(pulses), 64'd1);
        checkOutput("t3_tp",     64'(tp),     64'd13);

        $display("[TB] timeout disabled, then flush of 2");
        cfg_timeout = '0;
        applyStimulus(1'b1, 16'h0050, '0, 32'h1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0051, '0, 32'h2, 1'b0, 1'b1);
        got = 0;
        for (int c = 0; c < 1000; c++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
            if (m_valid) got++;
        end
        checkOutput("t4_no_timeout", 64'(got), 64'd0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("t4_mvalid", 64'(m_valid), 64'd1);
        checkOutput("t4_reason", 64'(reason),  64'd3);
        checkOutput("t4_size",   64'(bsize),   64'd2);
        checkOutput("t4_mid",    64'(m_id),    64'h50);
        drainBatch(got, pulses);
        checkOutput("t4_got", 64'(got), 64'd2);
        checkOutput("t4_tp",  64'(tp),  64'd15);

        got = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, '0, '0, '0, c < 5, 1'b1);
            if (m_valid) got++;
        end
        checkOutput("t4_empty_flush", 64'(got), 64'd0);

        $display("[TB] backpressure during a 4-entry drain");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, ID_W'(16'h60 + i), '0, DEP_W'(1) << (16 + i), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b0, (c % 2) == 0);
            if (m_valid) begin
                checkOutput("t5_id",   64'(m_id),   64'(16'h60 + idx));
                checkOutput("t5_wr",   64'(m_wr),   64'(DEP_W'(1) << (16 + idx)));
                checkOutput("t5_last", 64'(m_last), 64'(idx == 3));
                if (m_ready) idx++;
            end
        end
        checkOutput("t5_count", 64'(idx), 64'd4);
        checkOutput("t5_tp",    64'(tp),  64'd19);
`ifdef BATCH_STATS_EN
        checkOutput("stat_full",     64'(st_full),  64'd1);
        checkOutput("stat_timeout",  64'(st_tmo),   64'd1);
        checkOutput("stat_conflict", 64'(st_conf),  64'd1);
        checkOutput("stat_flush",    64'(st_flush), 64'd3);
`endif

        $display("[TB] reset in the middle of a drain");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, ID_W'(16'h70 + i), '0, DEP_W'(1) << (24 + i), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("t6_mid_drain", 64'(m_id), 64'h71);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_mvalid", 64'(m_valid), 64'd0);
        checkOutput("t6_rst_mid",    64'(m_id),    64'd0);
        checkOutput("t6_rst_size",   64'(bsize),   64'd0);
        checkOutput("t6_rst_tp",     64'(tp),      64'd0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("t6_rst_hold", 64'(m_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h0077, 32'h0100_0000, 32'h0200_0000, 1'b0, 1'b0);
        checkOutput("t6_sready", 64'(s_ready), 64'd1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("t6_mvalid", 64'(m_valid), 64'd1);
        checkOutput("t6_mid",    64'(m_id),    64'h77);
        checkOutput("t6_mlast",  64'(m_last),  64'd1);
        checkOutput("t6_size",   64'(bsize),   64'd1);
        drainBatch(got, pulses);
        checkOutput("t6_got", 64'(got), 64'd1);
        checkOutput("t6_tp",  64'(tp),  64'd1);
`ifdef BATCH_STATS_EN
        checkOutput("stat_flush_after_rst", 64'(st_flush), 64'd1);
        checkOutput("stat_full_after_rst",  64'(st_full),  64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 300000ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
